// File: rtl/color_convert_2_hls_deadlock_reporter.sv
// Debounced, sticky deadlock report for the color_convert_2 HLS deadlock monitors.
// Optional sticky block history port: define DEADLOCK_REPORTER_HIST_EN.
module color_convert_2_hls_deadlock_reporter #(
    parameter int NUM_MONITORS   = 4,
    parameter int PERSIST_CYCLES = 1024,
    parameter int CNT_W          = 32,
    parameter int IDX_W          = (NUM_MONITORS > 1) ? $clog2(NUM_MONITORS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_MONITORS-1:0] block_sigs,
    input  logic                    clear,
    output logic                    armed,
    output logic                    deadlock,
    output logic [IDX_W-1:0]        deadlock_idx,
    output logic [CNT_W-1:0]        deadlock_cycle
`ifdef DEADLOCK_REPORTER_HIST_EN
    ,
    output logic [NUM_MONITORS-1:0] block_hist
`endif
);

    localparam int PC_W = $clog2(PERSIST_CYCLES + 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERSIST_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        LOCKED
    } state_t;

    state_t            r_state, w_state_nx;
    logic [PC_W-1:0]   r_pcnt, w_pcnt_nx;
    logic [CNT_W-1:0]  r_cyc, w_cyc_nx;
    logic [CNT_W-1:0]  r_dcyc, w_dcyc_nx;
    logic [IDX_W-1:0]  r_idx, w_idx_nx;
    logic [IDX_W-1:0]  w_low_idx;
    logic              w_any;
    logic              w_lock;

    assign w_any = |block_sigs;

    // Lowest set bit wins, so scan from the top down.
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
            if (block_sigs[i]) w_low_idx = IDX_W'(i);
        end
    end

    assign w_cyc_nx = (&r_cyc) ? r_cyc : r_cyc + CNT_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_pcnt_nx  = r_pcnt;
        w_idx_nx   = r_idx;
        w_dcyc_nx  = r_dcyc;
        w_lock     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (PERSIST_CYCLES == 1) begin
                        w_lock = 1'b1;
                    end else begin
                        w_state_nx = ARM;
                        w_pcnt_nx  = PC_W'(1);
                    end
                end
            end
            ARM: begin
                if (!w_any) begin
                    w_state_nx = IDLE;
                    w_pcnt_nx  = '0;
                end else if (r_pcnt == PC_LAST) begin
                    w_lock = 1'b1;
                end else begin
                    w_pcnt_nx = r_pcnt + PC_W'(1);
                end
            end
            LOCKED: ;
            default: begin
                w_state_nx = IDLE;
                w_pcnt_nx  = '0;
            end
        endcase
        if (w_lock) begin
            w_state_nx = LOCKED;
            w_pcnt_nx  = '0;
            w_idx_nx   = w_low_idx;
            w_dcyc_nx  = r_cyc;
        end
        // Clear beats a same-edge lock.
        if (clear) begin
            w_state_nx = IDLE;
            w_pcnt_nx  = '0;
            w_idx_nx   = '0;
            w_dcyc_nx  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pcnt  <= '0;
            r_cyc   <= '0;
            r_idx   <= '0;
            r_dcyc  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pcnt  <= w_pcnt_nx;
            r_cyc   <= w_cyc_nx;
            r_idx   <= w_idx_nx;
            r_dcyc  <= w_dcyc_nx;
        end
    end

    assign armed          = (r_state == ARM);
    assign deadlock       = (r_state == LOCKED);
    assign deadlock_idx   = r_idx;
    assign deadlock_cycle = r_dcyc;

`ifdef DEADLOCK_REPORTER_HIST_EN
    logic [NUM_MONITORS-1:0] r_hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
        end else if (clear) begin
            r_hist <= '0;
        end else if (r_state != LOCKED) begin
            r_hist <= r_hist | block_sigs;
        end
    end

    assign block_hist = r_hist;
`endif

endmodule
